// File: rtl/core_pkg.sv
// Shared core definitions: register-file geometry and the encoding used to
// report which source an operand bypass was taken from.
package core_pkg;

   localparam int XLEN   = 32;
   localparam int RIDX_W = 5;

   // Architectural zero register; never a forwarding target.
   localparam int ZERO_REG = 0;

   // Hit-source encoding: register file, live ALU output, then history
   // entry k reported as HIT_HIST_BASE + k.
   localparam int HIT_SRC_W = 3;
   localparam logic [HIT_SRC_W-1:0] HIT_RF        = 3'd0;
   localparam logic [HIT_SRC_W-1:0] HIT_LIVE      = 3'd1;
   localparam logic [HIT_SRC_W-1:0] HIT_HIST_BASE = 3'd2;

endpackage

// File: rtl/bypass_hist_line.sv
// Shift register of recent results {valid, idx, value}. Entry 0 is the
// newest; every entry is visible in parallel for the bypass comparators.
module bypass_hist_line #(
   parameter int IDX_W = 5,
   parameter int VAL_W = 32,
   parameter int DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push_valid,
   input  logic [IDX_W-1:0]            push_idx,
   input  logic [VAL_W-1:0]            push_value,
   output logic [DEPTH-1:0]            ent_valid,
   output logic [DEPTH-1:0][IDX_W-1:0] ent_idx,
   output logic [DEPTH-1:0][VAL_W-1:0] ent_value
);

   // Shift a new result in at entry 0 every cycle; the oldest falls off the end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_valid <= '0;
         ent_idx   <= '0;
         ent_value <= '0;
      end else begin
         ent_valid[0] <= push_valid;
         ent_idx[0]   <= push_idx;
         ent_value[0] <= push_value;
         for (int k = 1; k < DEPTH; k++) begin
            ent_valid[k] <= ent_valid[k-1];
            ent_idx[k]   <= ent_idx[k-1];
            ent_value[k] <= ent_value[k-1];
         end
      end
   end

endmodule

// File: rtl/operand_bypass.sv
// Pre-ALU operand forwarding. Each of Rs/Rt takes the newest in-flight
// result for its register: the live ALU output first, then the history
// (newest entry first), else the register-file value. Register 0 is never
// forwarded. HIST_DEPTH is legal from 1 to 4 so the hit code fits 3 bits.
// Optional macro OPERAND_BYPASS_HIT_FLAGS_EN exposes rs_hit_src/rt_hit_src.
module operand_bypass #(
   parameter int XLEN       = core_pkg::XLEN,
   parameter int RIDX_W     = core_pkg::RIDX_W,
   parameter int HIST_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RIDX_W-1:0] rs_index,
   input  logic [RIDX_W-1:0] rt_index,
   input  logic [XLEN-1:0]   rs_val,
   input  logic [XLEN-1:0]   rt_val,
   input  logic [RIDX_W-1:0] rd_index,
   input  logic [XLEN-1:0]   rd_value,
   input  logic              rd_we,
`ifdef OPERAND_BYPASS_HIT_FLAGS_EN
   output logic [2:0]        rs_hit_src,
   output logic [2:0]        rt_hit_src,
`else
   // Hit-source trace ports are absent in the default build.
`endif
   output logic [XLEN-1:0]   bypassed_rs_val,
   output logic [XLEN-1:0]   bypassed_rt_val
);

   import core_pkg::*;

   localparam logic [RIDX_W-1:0] ZERO_IDX = RIDX_W'(ZERO_REG);

   logic                              live_valid;
   logic [HIST_DEPTH-1:0]             hist_valid;
   logic [HIST_DEPTH-1:0][RIDX_W-1:0] hist_idx;
   logic [HIST_DEPTH-1:0][XLEN-1:0]   hist_value;
   logic [HIT_SRC_W-1:0]              rs_src;
   logic [HIT_SRC_W-1:0]              rt_src;

   assign live_valid = rd_we && (rd_index != ZERO_IDX);

   bypass_hist_line #(
      .IDX_W (RIDX_W),
      .VAL_W (XLEN),
      .DEPTH (HIST_DEPTH)
   ) u_hist (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (live_valid),
      .push_idx   (rd_index),
      .push_value (rd_value),
      .ent_valid  (hist_valid),
      .ent_idx    (hist_idx),
      .ent_value  (hist_value)
   );

   // Priority search: live output beats every history entry, and within the
   // history the lowest (newest) entry wins. Index 0 always reports a miss.
   function automatic logic [HIT_SRC_W-1:0] find_src(input logic [RIDX_W-1:0] op_idx);
      logic [HIT_SRC_W-1:0] src;
      logic                 found;
      src   = HIT_RF;
      found = 1'b0;
      if (op_idx != ZERO_IDX) begin
         if (live_valid && (rd_index == op_idx)) begin
            src   = HIT_LIVE;
            found = 1'b1;
         end
         for (int k = 0; k < HIST_DEPTH; k++) begin
            if (!found && hist_valid[k] && (hist_idx[k] == op_idx)) begin
               src   = HIT_HIST_BASE + HIT_SRC_W'(k);
               found = 1'b1;
            end
         end
      end
      return src;
   endfunction

   // Turn a hit-source code into the operand value it names.
   function automatic logic [XLEN-1:0] select_val(input logic [HIT_SRC_W-1:0] src,
                                                   input logic [XLEN-1:0]      rf_val);
      logic [XLEN-1:0] val;
      val = rf_val;
      if (src == HIT_LIVE) begin
         val = rd_value;
      end
      for (int k = 0; k < HIST_DEPTH; k++) begin
         if (src == HIT_HIST_BASE + HIT_SRC_W'(k)) begin
            val = hist_value[k];
         end
      end
      return val;
   endfunction

   // Resolve Rs and Rt independently; both may hit the same source.
   always_comb begin
      rs_src          = find_src(rs_index);
      rt_src          = find_src(rt_index);
      bypassed_rs_val = select_val(rs_src, rs_val);
      bypassed_rt_val = select_val(rt_src, rt_val);
   end

`ifdef OPERAND_BYPASS_HIT_FLAGS_EN
   assign rs_hit_src = rs_src;
   assign rt_hit_src = rt_src;
`else
   // Hit codes still steer the value muxes; they are simply not exported.
`endif

endmodule

// File: tb/tb_operand_bypass.sv
// Directed bench for operand_bypass with the default HIST_DEPTH of 2.
// Inputs change 2 time units after a rising edge; outputs are checked 1
// unit later, well away from the next edge.
module tb_operand_bypass;

   localparam int XLEN   = 32;
   localparam int RIDX_W = 5;
   localparam int DEPTH  = 2;

   logic              clk;
   logic              rst_n;
   logic [RIDX_W-1:0] rs_index;
   logic [RIDX_W-1:0] rt_index;
   logic [XLEN-1:0]   rs_val;
   logic [XLEN-1:0]   rt_val;
   logic [RIDX_W-1:0] rd_index;
   logic [XLEN-1:0]   rd_value;
   logic              rd_we;
   logic [XLEN-1:0]   bypassed_rs_val;
   logic [XLEN-1:0]   bypassed_rt_val;

   int errors = 0;
   int checks = 0;

   operand_bypass #(
      .XLEN       (XLEN),
      .RIDX_W     (RIDX_W),
      .HIST_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rs_index        (rs_index),
      .rt_index        (rt_index),
      .rs_val          (rs_val),
      .rt_val          (rt_val),
      .rd_index        (rd_index),
      .rd_value        (rd_value),
      .rd_we           (rd_we),
      .bypassed_rs_val (bypassed_rs_val),
      .bypassed_rt_val (bypassed_rt_val)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [RIDX_W-1:0] rsi, input logic [XLEN-1:0] rsv,
                                input logic [RIDX_W-1:0] rti, input logic [XLEN-1:0] rtv,
                                input logic we, input logic [RIDX_W-1:0] rdi,
                                input logic [XLEN-1:0] rdv);
      rs_index = rsi;
      rs_val   = rsv;
      rt_index = rti;
      rt_val   = rtv;
      rd_we    = we;
      rd_index = rdi;
      rd_value = rdv;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [XLEN-1:0] exp_rs,
                              input logic [XLEN-1:0] exp_rt);
      checks++;
      assert (bypassed_rs_val === exp_rs) else begin
         errors++;
         $error("[TB] FAIL %s rs observed=%h expected=%h", tag, bypassed_rs_val, exp_rs);
      end
      checks++;
      assert (bypassed_rt_val === exp_rt) else begin
         errors++;
         $error("[TB] FAIL %s rt observed=%h expected=%h", tag, bypassed_rt_val, exp_rt);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #3;
      // During reset only the live source can forward.
      applyStimulus(5'd3, 32'h1, 5'd4, 32'h2, 1'b1, 5'd3, 32'h33);
      checkOutput("in_reset_live", 32'h33, 32'h2);
      tick();
      applyStimulus(5'd3, 32'h1, 5'd4, 32'h2, 1'b0, 5'd0, 32'h0);
      checkOutput("in_reset_hist_empty", 32'h1, 32'h2);
      rst_n = 1'b1;
      tick();

      // No writes in flight: register-file values pass through.
      applyStimulus(5'd3, 32'h11, 5'd0, 32'h7, 1'b0, 5'd0, 32'h0);
      checkOutput("rf_passthru", 32'h11, 32'h7);

      // Live forward, same cycle; Rt on another register is untouched.
      applyStimulus(5'd3, 32'h11, 5'd4, 32'h22, 1'b1, 5'd3, 32'hAAAA);
      checkOutput("live_fwd", 32'hAAAA, 32'h22);
      tick();
      applyStimulus(5'd3, 32'h1, 5'd3, 32'h2, 1'b0, 5'd0, 32'h0);
      checkOutput("h0_both_ops", 32'hAAAA, 32'hAAAA);
      tick();
      applyStimulus(5'd3, 32'h1, 5'd6, 32'h2, 1'b0, 5'd0, 32'h0);
      checkOutput("h1_hit", 32'hAAAA, 32'h2);
      tick();
      applyStimulus(5'd3, 32'h1, 5'd6, 32'h2, 1'b0, 5'd0, 32'h0);
      checkOutput("r3_aged_out", 32'h1, 32'h2);

      // Two writes to r5: live beats history, then newest history wins.
      applyStimulus(5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h100);
      tick();
      applyStimulus(5'd5, 32'h0, 5'd6, 32'h9, 1'b1, 5'd5, 32'h200);
      checkOutput("live_over_hist", 32'h200, 32'h9);
      tick();
      applyStimulus(5'd5, 32'h0, 5'd5, 32'h4, 1'b0, 5'd5, 32'h999);
      checkOutput("newest_hist_wins", 32'h200, 32'h200);
      tick();
      applyStimulus(5'd5, 32'h3, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("we0_not_in_h0", 32'h200, 32'h0);
      tick();
      applyStimulus(5'd5, 32'h3, 5'd0, 32'h0, 1'b0, 5'd5, 32'h999);
      checkOutput("we0_live_no_fwd", 32'h3, 32'h0);
      tick();

      // Writes to register 0 never forward, live or from history.
      applyStimulus(5'd0, 32'h0, 5'd0, 32'h44, 1'b1, 5'd0, 32'hDEAD);
      checkOutput("zero_live", 32'h0, 32'h44);
      tick();
      applyStimulus(5'd0, 32'h8, 5'd0, 32'h9, 1'b0, 5'd0, 32'h0);
      checkOutput("zero_hist", 32'h8, 32'h9);
      tick();

      // r7 ages out after DEPTH+1 idle cycles.
      applyStimulus(5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
      tick();
      applyStimulus(5'd7, 32'h5, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("r7_in_h0", 32'h77, 32'h0);
      for (int i = 0; i < DEPTH + 1; i++) tick();
      applyStimulus(5'd7, 32'h5, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("r7_aged_out", 32'h5, 32'h0);

      // Mid-cycle asynchronous reset wipes a loaded history.
      applyStimulus(5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
      tick();
      applyStimulus(5'd9, 32'h1, 5'd9, 32'h2, 1'b0, 5'd0, 32'h0);
      checkOutput("r9_loaded", 32'h99, 32'h99);
      rst_n = 1'b0;
      #1;
      checkOutput("r9_async_clear", 32'h1, 32'h2);
      #1;
      rst_n = 1'b1;
      tick();
      applyStimulus(5'd9, 32'h1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("r9_after_reset", 32'h1, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
